// File: rtl/multicycle_controller.sv
// Multicycle MIPS-style control unit: a Moore FSM that sequences fetch, decode,
// execute, memory and writeback, plus the combinational ALU function decoder.

module mc_aludec (
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);
  always_comb begin
    alucontrol = 3'b010;
    case (aluop)
      2'b01: alucontrol = 3'b110;
      2'b10: begin
        case (funct)
          6'h20:   alucontrol = 3'b010;
          6'h22:   alucontrol = 3'b110;
          6'h24:   alucontrol = 3'b000;
          6'h25:   alucontrol = 3'b001;
          6'h2A:   alucontrol = 3'b111;
          default: alucontrol = 3'b010;
        endcase
      end
      default: alucontrol = 3'b010;
    endcase
  end
endmodule

module multicycle_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic       Branch,
  output logic       PCWrite,
  output logic       PCEn,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic [1:0] ALUOp,
  output logic [2:0] ALUControl,
  output logic [3:0] state
);
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMRD    = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWR    = 4'd5;
  localparam logic [3:0] S_EXECUTE  = 4'd6;
  localparam logic [3:0] S_ALUWB    = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_ADDIEXEC = 4'd9;
  localparam logic [3:0] S_ADDIWB   = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  logic [3:0] state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  assign state = state_q;

  // op is only consulted in DECODE and MEMADR, where the IR is already stable.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEXEC;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:    state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:    state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXECUTE:  state_d = S_ALUWB;
      S_ADDIEXEC: state_d = S_ADDIWB;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    IorD     = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    Branch   = 1'b0;
    PCWrite  = 1'b0;
    ALUSrcB  = 2'b00;
    PCSrc    = 2'b00;
    ALUOp    = 2'b00;
    case (state_q)
      S_FETCH: begin
        // Gated by rst_n so a held reset never lets a ready memory fire writes.
        ALUSrcB = 2'b01;
        IRWrite = mem_ready & rst_n;
        PCWrite = mem_ready & rst_n;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_MEMADR, S_ADDIEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: IorD = 1'b1;
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_ADDIWB: RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b01;
        PCSrc   = 2'b01;
        Branch  = 1'b1;
      end
      S_JUMP: begin
        PCSrc   = 2'b10;
        PCWrite = 1'b1;
      end
      default: ;
    endcase
  end

  assign PCEn = PCWrite | (Branch & zero);

  mc_aludec u_aludec (
    .aluop      (ALUOp),
    .funct      (funct),
    .alucontrol (ALUControl)
  );
endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: instruction table, randomized run against a
// path-based reference model, and hand-written stall/reset/branch sequences.

module tb_multicycle_controller;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op, funct;
  logic       zero, mem_ready;
  logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, Branch, PCWrite, PCEn;
  logic [1:0] ALUSrcB, PCSrc, ALUOp;
  logic [2:0] ALUControl;
  logic [3:0] state;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .Branch(Branch), .PCWrite(PCWrite), .PCEn(PCEn),
    .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .ALUOp(ALUOp), .ALUControl(ALUControl), .state(state)
  );

  // Order: IorD MemWrite IRWrite RegDst MemtoReg RegWrite ALUSrcA Branch PCWrite PCEn
  //        ALUSrcB PCSrc ALUOp ALUControl state
  logic [22:0] act_vec;
  assign act_vec = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, Branch,
                    PCWrite, PCEn, ALUSrcB, PCSrc, ALUOp, ALUControl, state};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs written straight from the per-state output table.
  function automatic logic [22:0] exp_vec(input int s, input logic mr, input logic z,
                                          input logic [5:0] f);
    logic iord, mw, irw, rd, m2r, rw, asa, br, pcw, pcen;
    logic [1:0] asb, pcs, aop;
    logic [2:0] ac;
    {iord, mw, irw, rd, m2r, rw, asa, br, pcw} = '0;
    asb = 2'b00; pcs = 2'b00; aop = 2'b00;
    case (s)
      0:     begin asb = 2'b01; irw = mr; pcw = mr; end
      1:     asb = 2'b11;
      2, 9:  begin asa = 1'b1; asb = 2'b10; end
      3:     iord = 1'b1;
      4:     begin m2r = 1'b1; rw = 1'b1; end
      5:     begin iord = 1'b1; mw = 1'b1; end
      6:     begin asa = 1'b1; aop = 2'b10; end
      7:     begin rd = 1'b1; rw = 1'b1; end
      8:     begin asa = 1'b1; aop = 2'b01; pcs = 2'b01; br = 1'b1; end
      10:    rw = 1'b1;
      11:    begin pcs = 2'b10; pcw = 1'b1; end
      default: ;
    endcase
    if (aop == 2'b01) ac = 3'b110;
    else if (aop == 2'b10 && f == 6'h22) ac = 3'b110;
    else if (aop == 2'b10 && f == 6'h24) ac = 3'b000;
    else if (aop == 2'b10 && f == 6'h25) ac = 3'b001;
    else if (aop == 2'b10 && f == 6'h2A) ac = 3'b111;
    else ac = 3'b010;
    pcen = pcw | (br & z);
    return {iord, mw, irw, rd, m2r, rw, asa, br, pcw, pcen, asb, pcs, aop, ac, s[3:0]};
  endfunction

  typedef struct {
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    int         cycles;
    int         regw;
    int         memw;
    int         pcen;   // PCEn pulses outside FETCH
    int         alu;    // ALUControl seen in EXECUTE, -1 = not applicable
  } vec_t;

  vec_t tbl[14];

  initial begin
    int cyc, rw_n, mw_n, pe_n, alu_seen, held;
    int ops[7];
    int fns[6];
    int path[$];

    tbl[0]  = '{op:6'h23, funct:6'h00, zero:1'b0, cycles:5, regw:1, memw:0, pcen:0, alu:-1};
    tbl[1]  = '{op:6'h2B, funct:6'h00, zero:1'b0, cycles:4, regw:0, memw:1, pcen:0, alu:-1};
    tbl[2]  = '{op:6'h00, funct:6'h20, zero:1'b0, cycles:4, regw:1, memw:0, pcen:0, alu:3'b010};
    tbl[3]  = '{op:6'h00, funct:6'h22, zero:1'b1, cycles:4, regw:1, memw:0, pcen:0, alu:3'b110};
    tbl[4]  = '{op:6'h00, funct:6'h24, zero:1'b0, cycles:4, regw:1, memw:0, pcen:0, alu:3'b000};
    tbl[5]  = '{op:6'h00, funct:6'h25, zero:1'b0, cycles:4, regw:1, memw:0, pcen:0, alu:3'b001};
    tbl[6]  = '{op:6'h00, funct:6'h2A, zero:1'b0, cycles:4, regw:1, memw:0, pcen:0, alu:3'b111};
    tbl[7]  = '{op:6'h00, funct:6'h3F, zero:1'b0, cycles:4, regw:1, memw:0, pcen:0, alu:3'b010};
    tbl[8]  = '{op:6'h08, funct:6'h00, zero:1'b0, cycles:4, regw:1, memw:0, pcen:0, alu:-1};
    tbl[9]  = '{op:6'h04, funct:6'h00, zero:1'b1, cycles:3, regw:0, memw:0, pcen:1, alu:-1};
    tbl[10] = '{op:6'h04, funct:6'h00, zero:1'b0, cycles:3, regw:0, memw:0, pcen:0, alu:-1};
    tbl[11] = '{op:6'h02, funct:6'h00, zero:1'b0, cycles:3, regw:0, memw:0, pcen:1, alu:-1};
    tbl[12] = '{op:6'h3F, funct:6'h20, zero:1'b1, cycles:2, regw:0, memw:0, pcen:0, alu:-1};
    tbl[13] = '{op:6'h01, funct:6'h00, zero:1'b0, cycles:2, regw:0, memw:0, pcen:0, alu:-1};

    ops = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h08, 6'h02, 6'h00};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00};

    // Reset with a ready memory: no writes may escape.
    rst_n = 1'b0; op = 6'h00; funct = 6'h00; zero = 1'b0; mem_ready = 1'b1;
    #3;
    check("reset_state", {28'd0, state}, 32'd0);
    check("reset_wen", {27'd0, IRWrite, PCWrite, PCEn, MemWrite, RegWrite}, 32'd0);
    tick();
    check("reset_wen_after_edge", {23'd0, IRWrite, PCWrite, PCEn, MemWrite, RegWrite, state}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Instruction table, mem_ready tied high.
    for (int i = 0; i < 14; i++) begin
      op = tbl[i].op; funct = tbl[i].funct; zero = tbl[i].zero; mem_ready = 1'b1;
      cyc = 0; rw_n = 0; mw_n = 0; pe_n = 0; alu_seen = -1;
      do begin
        #2;
        rw_n += int'(RegWrite);
        mw_n += int'(MemWrite);
        if (state != 4'd0 && PCEn) pe_n++;
        if (state == 4'd6) alu_seen = int'(ALUControl);
        tick();
        cyc++;
      end while (state != 4'd0 && cyc < 20);
      check($sformatf("tbl%0d_cycles", i), cyc, tbl[i].cycles);
      check($sformatf("tbl%0d_regwrite", i), rw_n, tbl[i].regw);
      check($sformatf("tbl%0d_memwrite", i), mw_n, tbl[i].memw);
      check($sformatf("tbl%0d_pcen", i), pe_n, tbl[i].pcen);
      if (tbl[i].alu >= 0) check($sformatf("tbl%0d_aluctl", i), alu_seen, tbl[i].alu);
    end

    // Randomized run: each instruction is a path of states; FETCH, MEMRD and
    // MEMWR repeat while memory is not ready.
    for (int n = 0; n < 300; n++) begin
      int idx, guard;
      logic mr;
      op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'(ops[$urandom_range(0, 6)]);
      funct = ($urandom_range(0, 5) == 0) ? 6'($urandom) : 6'(fns[$urandom_range(0, 5)]);
      case (op)
        6'h23:   path = '{0, 1, 2, 3, 4};
        6'h2B:   path = '{0, 1, 2, 5};
        6'h00:   path = '{0, 1, 6, 7};
        6'h04:   path = '{0, 1, 8};
        6'h08:   path = '{0, 1, 9, 10};
        6'h02:   path = '{0, 1, 11};
        default: path = '{0, 1};
      endcase
      idx = 0; guard = 0;
      while (idx < path.size() && guard < 200) begin
        mr = ($urandom_range(0, 2) != 0);
        mem_ready = mr;
        zero = 1'($urandom);
        #2;
        check($sformatf("rand%0d_s%0d", n, path[idx]), {9'd0, act_vec},
              {9'd0, exp_vec(path[idx], mr, zero, funct)});
        tick();
        if (!((path[idx] == 0 || path[idx] == 3 || path[idx] == 5) && !mr)) idx++;
        guard++;
      end
      if (guard >= 200) check("rand_timeout", guard, 0);
    end

    // sw with three stalled cycles in MEMWR.
    op = 6'h2B; funct = 6'h00; zero = 1'b0; mem_ready = 1'b1;
    #2; check("sw_start_fetch", {28'd0, state}, 32'd0);
    tick(); tick(); tick();
    check("sw_in_memwr", {28'd0, state}, 32'd5);
    held = 0;
    for (int k = 0; k < 4; k++) begin
      mem_ready = (k == 3);
      #2;
      if (state == 4'd5 && MemWrite) held++;
      tick();
    end
    check("sw_memwr_held", held, 4);
    check("sw_back_to_fetch", {28'd0, state}, 32'd0);

    // Reset pulse in the middle of MEMWR takes effect without a clock edge.
    mem_ready = 1'b1;
    tick(); tick(); tick();
    mem_ready = 1'b0;
    check("rst_mid_in_memwr", {31'd0, MemWrite}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_state", {28'd0, state}, 32'd0);
    check("rst_mid_memwrite", {31'd0, MemWrite}, 32'd0);
    mem_ready = 1'b1;
    #1;
    check("rst_mid_wen", {27'd0, IRWrite, PCWrite, PCEn, MemWrite, RegWrite}, 32'd0);
    tick(); tick();
    @(negedge clk);
    rst_n = 1'b1; mem_ready = 1'b0;
    tick();
    check("post_rst_hold", {28'd0, state}, 32'd0);
    mem_ready = 1'b1;
    #2; check("post_rst_irwrite", {31'd0, IRWrite}, 32'd1);
    tick();
    check("post_rst_fetch", {28'd0, state}, 32'd1);

    // beq: PCEn follows zero combinationally while in BRANCH.
    op = 6'h04;
    tick();
    check("beq_in_branch", {28'd0, state}, 32'd8);
    zero = 1'b1; #1;
    check("beq_z1_pcen", {29'd0, PCEn, PCSrc}, {29'd0, 1'b1, 2'b01});
    zero = 1'b0; #1;
    check("beq_z0_pcen", {31'd0, PCEn}, 32'd0);
    tick();
    check("beq_done", {28'd0, state}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have port op  input  6  instruction opcode, IR[31:26].
REQ-004 SHALL have port funct  input  6  R-type function field, IR[5:0].
REQ-005 SHALL have port zero  input  1  ALU zero flag.
REQ-006 SHALL have port mem_ready  input  1  memory access done this cycle.
REQ-007 SHALL have outputs IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, Branch, PCWrite, PCEn; each is 1 bit.
REQ-008 SHALL have outputs ALUSrcB  2, PCSrc  2, ALUOp  2, ALUControl  3.
REQ-009 SHALL have output state  4  current state code, for debug and verification.

Function
REQ-010 SHALL implement a Moore FSM with these state codes:
- FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
- EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11
REQ-011 SHALL hold FETCH while mem_ready=0 and go FETCH->DECODE when mem_ready=1.
REQ-012 SHALL make the DECODE transition on op:
- 0x23 lw, 0x2B sw -> MEMADR
- 0x00 R-type -> EXECUTE
- 0x04 beq -> BRANCH
- 0x08 addi -> ADDIEXEC
- 0x02 j -> JUMP
- any other op -> FETCH, with no register or memory write
REQ-013 SHALL go MEMADR->MEMRD if op=0x23; otherwise MEMADR->MEMWR.
REQ-014 SHALL hold MEMRD and MEMWR while mem_ready=0; on mem_ready=1, MEMRD->MEMWB and MEMWR->FETCH.
REQ-015 SHALL transition MEMWB, ALUWB, ADDIWB, BRANCH, JUMP -> FETCH; EXECUTE->ALUWB; ADDIEXEC->ADDIWB; no other waits.
REQ-016 SHALL drive every unlisted output 0 in every state; per-state outputs:
- FETCH: ALUSrcB=01; IRWrite=PCWrite=mem_ready
- DECODE: ALUSrcB=11
- MEMADR, ADDIEXEC: ALUSrcA=1, ALUSrcB=10
- MEMRD: IorD=1
- MEMWR: IorD=1, MemWrite=1 for the whole stay
- MEMWB: MemtoReg=1, RegWrite=1
- EXECUTE: ALUSrcA=1, ALUOp=10
- ALUWB: RegDst=1, RegWrite=1
- ADDIWB: RegWrite=1
- BRANCH: ALUSrcA=1, ALUOp=01, PCSrc=01, Branch=1
- JUMP: PCSrc=10, PCWrite=1
REQ-017 SHALL drive PCEn = PCWrite | (Branch & zero), combinationally.
REQ-018 SHALL decode ALUControl combinationally, latch-free:
- ALUOp 00 -> 010; ALUOp 01 -> 110
- ALUOp 10 with funct 0x20 -> 010, 0x22 -> 110, 0x24 -> 000, 0x25 -> 001, 0x2A -> 111
- unknown funct, or ALUOp 11 -> 010
REQ-019 SHALL give these latencies with mem_ready tied 1: lw 5 cycles; sw, R-type, addi 4 cycles; beq, j 3 cycles.
REQ-020 SHALL treat any unused state code as FETCH on the next edge, with all outputs 0 meanwhile.
REQ-021 SHALL sample op and funct only in states that use them; the IR is stable after FETCH.

Reset
REQ-022 SHALL force state=FETCH immediately on rst_n=0, independent of clk.
REQ-023 SHALL, during reset, drive all write enables (IRWrite, PCWrite, PCEn, MemWrite, RegWrite) to 0, regardless of mem_ready.
REQ-024 SHALL abandon an in-progress instruction on reset assertion mid-instruction, with no further writes; after rst_n rises, the first edge with mem_ready=1 performs a fetch.

Verification
REQ-025 SHALL pass: lw (op=0x23), mem_ready=1 -> states 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4.
REQ-026 SHALL pass: sw (op=0x2B), mem_ready=0 for 3 cycles in MEMWR -> state 5 held 4 cycles, MemWrite=1 throughout, then state 0.
REQ-027 SHALL pass: R-type funct=0x2A -> in EXECUTE ALUOp=10, ALUControl=111; in ALUWB RegDst=1, RegWrite=1.
REQ-028 SHALL pass: beq in BRANCH state with zero=1 -> PCEn=1, PCSrc=01; with zero=0 -> PCEn=0.
REQ-029 SHALL pass: op=0x3F -> 0,1,0, with RegWrite, MemWrite and PCEn never 1 outside FETCH.
REQ-030 SHALL pass: rst_n pulsed low mid-MEMWR -> state=0 and MemWrite=0 within the same cycle, before the next clk edge.
